// File: rtl/spi_slave_port.sv
// SPI mode-0 responder: oversampled CS/SCK/MOSI, WORD_BITS-bit words in (out_wr) and out (spi_miso), back-to-back words per frame.
// out_wr and spi_miso lag the raw SCK/CS edge by SYNC_STAGES+2 clk; no backpressure, out_wr is a single-cycle strobe.
module spi_slave_port #(
   parameter int WORD_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_cs,
   input  logic                 spi_clk,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   input  logic [WORD_BITS-1:0] in_data,
   input  logic                 in_wr,
   output logic [WORD_BITS-1:0] out_data,
   output logic                 out_wr,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 underrun
);
   localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   logic                   cs_prev_q, sck_prev_q;
   logic                   cs_fall_q, cs_rise_q, sck_rise_q, sck_fall_q, mosi_q;
   logic                   cs_s, sck_s;

   state_t                 state_q;
   logic [CW-1:0]          bit_cnt_q;
   logic [WORD_BITS-1:0]   rx_q, tx_q, reply_q, out_data_q;
   logic                   pending_q, skip_fall_q;
   logic                   owed_q, owed_hit_q, owed_clr_q;
   logic                   miso_q, out_wr_q, busy_q, frame_err_q, underrun_q;
   logic [WORD_BITS-1:0]   load_word_d;

   assign cs_s  = cs_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];

   // CS chain resets to "low" so a CS already low at reset release never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b0;
         sck_prev_q  <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         sck_rise_q  <= 1'b0;
         sck_fall_q  <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_prev_q   <= cs_s;
         sck_prev_q  <= sck_s;
         cs_fall_q   <= cs_prev_q & ~cs_s;
         cs_rise_q   <= ~cs_prev_q & cs_s;
         sck_rise_q  <= ~sck_prev_q & sck_s;
         sck_fall_q  <= sck_prev_q & ~sck_s;
         mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
      end
   end

   // A same-cycle in_wr wins over the held reply.
   always_comb begin
      load_word_d = '0;
      if (in_wr) begin
         load_word_d = in_data;
      end else if (pending_q) begin
         load_word_d = reply_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         reply_q     <= '0;
         out_data_q  <= '0;
         pending_q   <= 1'b0;
         skip_fall_q <= 1'b0;
         owed_q      <= 1'b0;
         owed_hit_q  <= 1'b0;
         owed_clr_q  <= 1'b0;
         miso_q      <= 1'b0;
         out_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         out_wr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
         if (in_wr) begin
            reply_q    <= in_data;
            pending_q  <= 1'b1;
            owed_clr_q <= 1'b0;
         end
         if (state_q == IDLE) begin
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            if (cs_fall_q) begin
               state_q     <= SHIFT;
               busy_q      <= 1'b1;
               skip_fall_q <= 1'b0;
               owed_q      <= 1'b0;
               tx_q        <= load_word_d;
               miso_q      <= load_word_d[WORD_BITS-1];
               if (in_wr || pending_q) begin
                  pending_q <= 1'b0;
               end else begin
                  underrun_q <= 1'b1;
               end
            end
         end else if (cs_rise_q) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
            owed_q    <= 1'b0;
            if (bit_cnt_q != '0) begin
               frame_err_q <= 1'b1;
            end
         end else begin
            if (sck_rise_q) begin
               rx_q <= {rx_q[WORD_BITS-2:0], mosi_q};
               // A boundary reload only consumes the reply once the host actually clocks the next word.
               if (owed_q) begin
                  owed_q <= 1'b0;
                  if (!owed_hit_q) begin
                     underrun_q <= 1'b1;
                  end else if (owed_clr_q && !in_wr) begin
                     pending_q <= 1'b0;
                  end
               end
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_q   <= '0;
                  out_data_q  <= {rx_q[WORD_BITS-2:0], mosi_q};
                  out_wr_q    <= 1'b1;
                  tx_q        <= load_word_d;
                  miso_q      <= load_word_d[WORD_BITS-1];
                  skip_fall_q <= 1'b1;
                  if (in_wr) begin
                     pending_q <= 1'b0;
                     owed_q    <= 1'b0;
                  end else begin
                     owed_q     <= 1'b1;
                     owed_hit_q <= pending_q;
                     owed_clr_q <= pending_q;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            if (sck_fall_q) begin
               if (skip_fall_q) begin
                  skip_fall_q <= 1'b0;
               end else begin
                  tx_q   <= {tx_q[WORD_BITS-2:0], 1'b0};
                  miso_q <= tx_q[WORD_BITS-2];
               end
            end
         end
      end
   end

   assign spi_miso  = miso_q;
   assign out_data  = out_data_q;
   assign out_wr    = out_wr_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Randomized bench for spi_slave_port: host-side SPI driver, reply model, and an out_wr scoreboard monitor.
module tb_spi_slave_port;
   localparam int W   = 24;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;

   logic         clk = 1'b0;
   logic         rst_n, spi_cs, spi_clk, spi_mosi, in_wr;
   logic [W-1:0] in_data;
   logic         spi_miso, out_wr, busy, frame_err, underrun;
   logic [W-1:0] out_data;

   spi_slave_port #(.WORD_BITS(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .in_data(in_data), .in_wr(in_wr), .out_data(out_data),
      .out_wr(out_wr), .busy(busy), .frame_err(frame_err), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct { logic [W-1:0] d; int cyc; } rx_exp_t;
   rx_exp_t rx_q[$];
   rx_exp_t mon_e;

   int checks = 0, failures = 0;
   int seen_under = 0, seen_ferr = 0, exp_under = 0, exp_ferr = 0;
   logic [W-1:0] m_reply;
   bit           m_pending;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every out_wr must match the oldest completed host word and its edge time.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_wr) begin
            if (rx_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_wr_unexpected: got strobe with data 0x%0h, expected none", out_data);
            end else begin
               mon_e = rx_q.pop_front();
               chk("out_data", out_data, mon_e.d);
               chk("out_wr_latency", cyc - mon_e.cyc, LAT);
            end
         end
         if (underrun)  seen_under++;
         if (frame_err) seen_ferr++;
      end
   end

   task automatic host_wr(input logic [W-1:0] d);
      in_data = d;
      in_wr   = 1'b1;
      @(negedge clk);
      in_wr     = 1'b0;
      m_reply   = d;
      m_pending = 1'b1;
   endtask

   task automatic model_take(output logic [W-1:0] r);
      if (m_pending) begin
         r         = m_reply;
         m_pending = 1'b0;
      end else begin
         r = '0;
         exp_under++;
      end
   endtask

   // wr_mode: 0 none, 1 in_wr mid-word, 2 in_wr on the clk cycle the DUT reloads after the last bit.
   task automatic xfer_word(input logic [W-1:0] mw, input int nbits, input bit exp_rx,
                            input int wr_mode, input logic [W-1:0] wr_d, output logic [W-1:0] got);
      got = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mw[W-1-i];
         repeat (4) @(negedge clk);
         spi_clk = 1'b1;
         got = {got[W-2:0], spi_miso};
         if (i == W-1 && exp_rx) rx_q.push_back('{mw, cyc});
         if (i == W-1 && wr_mode == 2) begin
            repeat (LAT-1) @(negedge clk);
            in_data = wr_d;
            in_wr   = 1'b1;
            @(negedge clk);
            in_wr = 1'b0;
         end else if (i == W/2 && wr_mode == 1) begin
            host_wr(wr_d);
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         spi_clk = 1'b0;
      end
   endtask

   task automatic run_frame(input int nw, input bit fix0, input logic [W-1:0] w0,
                            input int mid_pct, input bit bnd_inj, input logic [W-1:0] bnd_d);
      logic [W-1:0] mw, expm, got, wd;
      int mode;
      spi_cs = 1'b0;
      model_take(expm);
      repeat (8) @(negedge clk);
      chk("busy_in_frame", busy, 1);
      for (int w = 0; w < nw; w++) begin
         mw   = (w == 0 && fix0) ? w0 : W'($urandom);
         wd   = W'($urandom);
         mode = 0;
         if (bnd_inj && w == 0 && nw > 1) begin
            mode = 2;
            wd   = bnd_d;
         end else if (int'($urandom_range(99)) < mid_pct) begin
            mode = 1;
         end
         xfer_word(mw, W, 1'b1, mode, wd, got);
         chk("miso_word", got, expm);
         if (w < nw-1) begin
            if (mode == 2) begin
               expm      = wd;
               m_pending = 1'b0;
            end else begin
               model_take(expm);
            end
         end
      end
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("miso_idle", spi_miso, 0);
   endtask

   initial begin
      logic [W-1:0] got, expm;
      int n, words;
      rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      in_wr = 1'b0; in_data = '0; m_pending = 1'b0; m_reply = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_wr", out_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_miso", spi_miso, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // single word with a loaded reply
      host_wr(24'hA5C3F0);
      run_frame(1, 1'b1, 24'h123456, 0, 1'b0, '0);
      chk("t1_underrun_cnt", seen_under, exp_under);

      // two words, reply only for the first
      host_wr(24'h5A5A5A);
      run_frame(2, 1'b0, '0, 0, 1'b0, '0);
      chk("t2_underrun_cnt", seen_under, exp_under);

      // CS raised after 10 bits
      host_wr(24'h777777);
      spi_cs = 1'b0;
      model_take(expm);
      repeat (8) @(negedge clk);
      xfer_word(W'($urandom), 10, 1'b0, 0, '0, got);
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      exp_ferr++;
      repeat (10) @(negedge clk);
      chk("t3_frame_err_cnt", seen_ferr, exp_ferr);
      host_wr(24'hC0FFEE);
      run_frame(1, 1'b0, '0, 0, 1'b0, '0);

      // in_wr coinciding with the word-boundary reload
      host_wr(24'h135790);
      run_frame(3, 1'b0, '0, 0, 1'b1, 24'h0F0F0F);
      chk("t4_underrun_cnt", seen_under, exp_under);

      // reset mid-word with CS held low
      host_wr(24'h111111);
      spi_cs = 1'b0;
      model_take(expm);
      repeat (8) @(negedge clk);
      xfer_word(W'($urandom), 10, 1'b0, 0, '0, got);
      rst_n     = 1'b0;
      m_pending = 1'b0;
      @(negedge clk);
      chk("t5_rst_out_data", out_data, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_miso", spi_miso, 0);
      chk("t5_rst_out_wr", out_wr, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      xfer_word(W'($urandom), W, 1'b0, 0, '0, got);
      chk("t5_busy_cs_low", busy, 0);
      chk("t5_miso_no_frame", got, 0);
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      host_wr(24'h2468AC);
      run_frame(1, 1'b1, 24'hBEEF01, 0, 1'b0, '0);
      chk("t5_underrun_cnt", seen_under, exp_under);
      chk("t5_frame_err_cnt", seen_ferr, exp_ferr);

      // random multi-word frames at SCK = clk/8
      words = 0;
      while (words < 250) begin
         n = int'($urandom_range(4, 1));
         if ($urandom_range(1) != 0) host_wr(W'($urandom));
         run_frame(n, 1'b0, '0, 40, 1'b0, '0);
         words += n;
      end
      chk("t6_underrun_cnt", seen_under, exp_under);
      chk("t6_frame_err_cnt", seen_ferr, exp_ferr);

      repeat (20) @(negedge clk);
      chk("rx_scoreboard_drained", rx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
